axis_rr_pkt_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter: merges N_IN AXI-Stream-style sources (valid/ready/data/last)

---
 rtl/axis_pkt_pkg.sv | 14 +
 rtl/axis_rr_pkt_arbiter_pick.sv | 33 +++
 rtl/axis_rr_pkt_arbiter.sv | 119 +++++++++++
 tb/tb_axis_rr_pkt_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared types and helpers for the packet arbiter slice.
// Holds the arbiter state enum and a safe index-width function.
package axis_pkt_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_PASS
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_pick.sv
// rr_pick: rotate-priority find-first, purely combinational.
// req: requests, ptr: start index -> gnt_idx: winner, gnt_any: any request.
module rr_pick
  import axis_pkt_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int j;

  // Walk offsets from far to near so the nearest
  // requester at or after ptr is the last one kept.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[IW'(j)]) begin
        gnt_idx = IW'(j);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging N_IN streams into one.
// Ports: clk/rst_n, enable, s_* sources, m_* master, m_src, busy, pkt_done, trunc_err.
module axis_rr_pkt_arbiter
  import axis_pkt_pkg::*;
#(
  parameter  int N_IN          = 4,
  parameter  int DATA_W        = 32,
  parameter  int MAX_PKT_BEATS = 256,
  localparam int IDX_W         = idx_w(N_IN),
  localparam int CNT_W         = $clog2(MAX_PKT_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_IN-1:0]        s_valid,
  output logic [N_IN-1:0]        s_ready,
  input  logic [N_IN*DATA_W-1:0] s_data,
  input  logic [N_IN-1:0]        s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_W-1:0]      m_data,
  output logic                   m_last,
  output logic [IDX_W-1:0]       m_src,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   trunc_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_PKT_BEATS - 1);
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(N_IN - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             pkt_done_q, pkt_done_d;
  logic             trunc_err_q, trunc_err_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             src_last;
  logic             fire;

  rr_pick #(
    .N(N_IN)
  ) u_pick (
    .req    (s_valid),
    .ptr    (rr_ptr_q),
    .gnt_idx(pick_idx),
    .gnt_any(pick_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_done_d  = 1'b0;
    trunc_err_d = 1'b0;
    s_ready     = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    src_last    = 1'b0;
    fire        = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (enable && pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ARB_PASS;
        end
      end
      ARB_PASS: begin
        m_valid          = s_valid[grant_q];
        m_data           = s_data[grant_q*DATA_W +: DATA_W];
        s_ready[grant_q] = m_ready;
        src_last         = s_last[grant_q];
        // The beat that reaches the limit is forced last.
        m_last           = src_last || (beat_cnt_q == LIMIT);
        fire             = m_valid && m_ready;
        if (fire) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (m_last) begin
            state_d     = ARB_IDLE;
            rr_ptr_d    = (grant_q == TOP_IDX) ? '0 : grant_q + 1'b1;
            pkt_done_d  = 1'b1;
            trunc_err_d = !src_last;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      pkt_done_q  <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_done_q  <= pkt_done_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign m_src     = grant_q;
  assign busy      = (state_q == ARB_PASS);
  assign pkt_done  = pkt_done_q;
  assign trunc_err = trunc_err_q;

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Directed bench for axis_rr_pkt_arbiter: vector tables plus
// hand sequences for back-pressure, wrap and mid-packet reset.
module tb_axis_rr_pkt_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable;
  logic [3:0]   s_valid;
  logic [127:0] s_data;
  logic [3:0]   s_last;
  logic         m_ready;

  logic [3:0]  s_ready, s_ready4;
  logic        m_valid, m_valid4;
  logic [31:0] m_data, m_data4;
  logic        m_last, m_last4;
  logic [1:0]  m_src, m_src4;
  logic        busy, busy4;
  logic        pkt_done, pkt_done4;
  logic        trunc_err, trunc_err4;

  always #5 clk = ~clk;

  axis_rr_pkt_arbiter #(
    .N_IN(4), .DATA_W(32), .MAX_PKT_BEATS(256)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last),
    .m_src(m_src), .busy(busy),
    .pkt_done(pkt_done), .trunc_err(trunc_err)
  );

  axis_rr_pkt_arbiter #(
    .N_IN(4), .DATA_W(32), .MAX_PKT_BEATS(4)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready4),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid4), .m_ready(m_ready),
    .m_data(m_data4), .m_last(m_last4),
    .m_src(m_src4), .busy(busy4),
    .pkt_done(pkt_done4), .trunc_err(trunc_err4)
  );

  typedef struct {
    logic        en;
    logic        mr;
    logic        busy;
    logic        mv;
    int          src;
    logic        ml;
    logic        pd;
    logic        te;
    logic [31:0] md;
  } vec_t;

  vec_t vt[64];
  int   nv = 0;
  int   nvec = 0;
  int   nerr = 0;

  logic [32:0] qm[4][32];
  int          qh[4];
  int          qt[4];

  function automatic logic [31:0] mkd(input int s, input int p, input int b);
    return {s[7:0], p[7:0], b[15:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic mr, input logic b,
                     input logic mv, input int src, input logic ml,
                     input logic pd, input logic te, input logic [31:0] md);
    vt[nv] = '{en, mr, b, mv, src, ml, pd, te, md};
    nv++;
  endtask

  task automatic add_idle(input logic en, input logic pd, input logic te);
    add(en, 1'b1, 1'b0, 1'b0, 0, 1'b0, pd, te, 32'h0);
  endtask

  task automatic add_beat(input logic en, input int src, input int p,
                          input int b, input logic ml);
    add(en, 1'b1, 1'b1, 1'b1, src, ml, 1'b0, 1'b0, mkd(src, p, b));
  endtask

  task automatic push_pkt(input int src, input int p, input int n);
    for (int b = 0; b < n; b++) begin
      qm[src][qt[src]] = {(b == n - 1), mkd(src, p, b)};
      qt[src]++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (qh[i] < qt[i]) begin
        s_valid[i]           = 1'b1;
        s_data[i*32 +: 32]   = qm[i][qh[i]][31:0];
        s_last[i]            = qm[i][qh[i]][32];
      end else begin
        s_valid[i]           = 1'b0;
        s_data[i*32 +: 32]   = 32'h0;
        s_last[i]            = 1'b0;
      end
    end
  endtask

  // Pop accepted beats at the edge, re-drive at the next falling edge.
  task automatic adv(input logic use4);
    logic [3:0] f;
    f = s_valid & (use4 ? s_ready4 : s_ready);
    @(posedge clk);
    for (int i = 0; i < 4; i++)
      if (f[i]) qh[i]++;
    @(negedge clk);
    drive();
  endtask

  task automatic reset_begin();
    rst_n   = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      qh[i] = 0;
      qt[i] = 0;
    end
  endtask

  task automatic reset_end();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive();
  endtask

  task automatic run_vecs(input int lo, input int hi, input logic use4);
    logic        o_busy, o_mv, o_pd, o_te, o_ml;
    logic [1:0]  o_src;
    logic [31:0] o_md;
    logic [3:0]  o_rdy, e_rdy;
    for (int k = lo; k < hi; k++) begin
      enable  = vt[k].en;
      m_ready = vt[k].mr;
      #1;
      o_busy = use4 ? busy4 : busy;
      o_mv   = use4 ? m_valid4 : m_valid;
      o_pd   = use4 ? pkt_done4 : pkt_done;
      o_te   = use4 ? trunc_err4 : trunc_err;
      o_ml   = use4 ? m_last4 : m_last;
      o_src  = use4 ? m_src4 : m_src;
      o_md   = use4 ? m_data4 : m_data;
      o_rdy  = use4 ? s_ready4 : s_ready;
      e_rdy  = (vt[k].busy && vt[k].mr) ? (4'b0001 << vt[k].src) : 4'b0000;
      chk($sformatf("v%0d busy", k), 32'(o_busy), 32'(vt[k].busy));
      chk($sformatf("v%0d m_valid", k), 32'(o_mv), 32'(vt[k].mv));
      chk($sformatf("v%0d pkt_done", k), 32'(o_pd), 32'(vt[k].pd));
      chk($sformatf("v%0d trunc_err", k), 32'(o_te), 32'(vt[k].te));
      chk($sformatf("v%0d s_ready", k), 32'(o_rdy), 32'(e_rdy));
      if (vt[k].mv) begin
        chk($sformatf("v%0d m_src", k), 32'(o_src), 32'(vt[k].src));
        chk($sformatf("v%0d m_last", k), 32'(o_ml), 32'(vt[k].ml));
        chk($sformatf("v%0d m_data", k), o_md, vt[k].md);
      end
      adv(use4);
    end
  endtask

  int t2_lo, t2_hi, t4_lo, t4_hi, t5_lo, t5_hi;
  int nb;

  initial begin
    s_valid = '0;
    s_data  = '0;
    s_last  = '0;
    enable  = 1'b1;
    m_ready = 1'b1;

    // Round-robin over four 3-beat packets then wrap to 0.
    t2_lo = nv;
    add_idle(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 5; p++) begin
      for (int b = 0; b < 3; b++)
        add_beat(1'b1, p % 4, p / 4, b, (b == 2));
      if (p < 4) add_idle(1'b1, 1'b1, 1'b0);
    end
    t2_hi = nv;

    // Truncation at 4 beats, remainder as a new packet.
    t4_lo = nv;
    add_idle(1'b1, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++)
      add_beat(1'b1, 1, 0, b, (b == 3));
    add_idle(1'b1, 1'b1, 1'b1);
    add_beat(1'b1, 1, 0, 4, 1'b0);
    add_beat(1'b1, 1, 0, 5, 1'b1);
    add_idle(1'b1, 1'b1, 1'b0);
    t4_hi = nv;

    // enable dropped mid-packet, held idle, then resumed at g+1.
    t5_lo = nv;
    add_idle(1'b1, 1'b0, 1'b0);
    add_beat(1'b1, 0, 0, 0, 1'b0);
    for (int b = 1; b < 5; b++)
      add_beat(1'b0, 0, 0, b, (b == 4));
    add_idle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      add_idle(1'b0, 1'b0, 1'b0);
    add_idle(1'b1, 1'b0, 1'b0);
    add_beat(1'b1, 1, 0, 0, 1'b0);
    add_beat(1'b1, 1, 0, 1, 1'b0);
    t5_hi = nv;

    @(negedge clk);

    // Reset values with every source requesting.
    reset_begin();
    for (int s = 0; s < 4; s++) begin
      push_pkt(s, 0, 3);
      push_pkt(s, 1, 3);
    end
    drive();
    #1;
    chk("rst s_ready", 32'(s_ready), 32'h0);
    chk("rst m_valid", 32'(m_valid), 32'h0);
    chk("rst m_last", 32'(m_last), 32'h0);
    chk("rst m_src", 32'(m_src), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst pkt_done", 32'(pkt_done), 32'h0);
    chk("rst trunc_err", 32'(trunc_err), 32'h0);
    chk("rst m_data", m_data, 32'h0);
    reset_end();
    run_vecs(t2_lo, t2_hi, 1'b0);

    // Back-pressure on source 2.
    reset_begin();
    push_pkt(2, 0, 4);
    reset_end();
    #1;
    chk("bp idle", 32'(busy), 32'h0);
    adv(1'b0);
    nb = 0;
    for (int c = 1; c < 8; c++) begin
      m_ready = c[0];
      #1;
      chk($sformatf("bp c%0d busy", c), 32'(busy), 32'h1);
      chk($sformatf("bp c%0d m_valid", c), 32'(m_valid), 32'h1);
      chk($sformatf("bp c%0d s_ready", c), 32'(s_ready),
          m_ready ? 32'h4 : 32'h0);
      if (m_valid && m_ready) begin
        chk($sformatf("bp beat%0d data", nb), m_data, mkd(2, 0, nb));
        chk($sformatf("bp beat%0d last", nb), 32'(m_last), 32'(nb == 3));
        nb++;
      end
      adv(1'b0);
    end
    m_ready = 1'b1;
    #1;
    chk("bp end busy", 32'(busy), 32'h0);
    chk("bp end pkt_done", 32'(pkt_done), 32'h1);
    chk("bp beats seen", 32'(nb), 32'h4);
    chk("bp beats popped", 32'(qh[2]), 32'h4);
    adv(1'b0);

    // Truncation on the 4-beat-limit instance.
    reset_begin();
    push_pkt(1, 0, 6);
    reset_end();
    run_vecs(t4_lo, t4_hi, 1'b1);

    // enable gating.
    reset_begin();
    push_pkt(0, 0, 5);
    push_pkt(0, 1, 5);
    push_pkt(1, 0, 5);
    reset_end();
    run_vecs(t5_lo, t5_hi, 1'b0);

    // Wrap 3 -> 0, then reset mid-packet.
    reset_begin();
    push_pkt(3, 0, 2);
    reset_end();
    #1;
    chk("wr c0 busy", 32'(busy), 32'h0);
    adv(1'b0);
    #1;
    chk("wr c1 m_src", 32'(m_src), 32'h3);
    chk("wr c1 m_data", m_data, mkd(3, 0, 0));
    adv(1'b0);
    #1;
    chk("wr c2 m_last", 32'(m_last), 32'h1);
    chk("wr c2 m_data", m_data, mkd(3, 0, 1));
    push_pkt(0, 0, 3);
    adv(1'b0);
    #1;
    chk("wr c3 busy", 32'(busy), 32'h0);
    chk("wr c3 pkt_done", 32'(pkt_done), 32'h1);
    adv(1'b0);
    #1;
    chk("wr c4 busy", 32'(busy), 32'h1);
    chk("wr c4 m_src", 32'(m_src), 32'h0);
    chk("wr c4 m_data", m_data, mkd(0, 0, 0));
    adv(1'b0);
    #1;
    chk("wr c5 busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'h0);
    chk("mid rst s_ready", 32'(s_ready), 32'h0);
    chk("mid rst m_valid", 32'(m_valid), 32'h0);
    chk("mid rst m_src", 32'(m_src), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
